// File: rtl/flopr_pkg.sv
// flopr_pkg: shared constants and the decoded register operation type
package flopr_pkg;
    localparam logic [31:0] FLOPR_NOP_32 = 32'h0000_0000;
    typedef enum logic [1:0] {OP_RESET, OP_FLUSH, OP_HOLD, OP_LOAD} flopr_op_e;
endpackage

// File: rtl/flopr_ctrl.sv
// flopr_ctrl: decodes reset/flush/stall into one register operation
// Ports: reset, flush, stall (in, active-high); op (out, flopr_op_e)
// Reset wins outright, so X on flush/stall while reset=1 still yields OP_RESET.
module flopr_ctrl
    import flopr_pkg::*;
(
    input  logic      reset,
    input  logic      flush,
    input  logic      stall,
    output flopr_op_e op
);
    always_comb begin
        op = reset ? OP_RESET : flush ? OP_FLUSH : stall ? OP_HOLD : OP_LOAD;
    end
endmodule

// File: rtl/flopr.sv
// flopr: pipeline register with sync reset, flush and stall
// Ports: clk; reset (sync, active-high); stall (hold); flush (load FLUSH_VALUE);
//        d [WIDTH-1:0] next data; q [WIDTH-1:0] registered data, straight from the flop.
// Macro FLOPR_TRACE_EN compiles in a simulation-only per-edge trace line.
module flopr
    import flopr_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = WIDTH'(FLOPR_NOP_32)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    flopr_op_e op;

    flopr_ctrl u_ctrl (
        .reset(reset),
        .flush(flush),
        .stall(stall),
        .op   (op)
    );

    always_ff @(posedge clk) begin
        case (op)
            OP_RESET: q <= RESET_VALUE;
            OP_FLUSH: q <= FLUSH_VALUE;
            OP_LOAD:  q <= d;
            default:  q <= q;
        endcase
    end

`ifdef FLOPR_TRACE_EN
    // $strobe reports q after this edge's update has settled.
    always @(posedge clk) begin
        $strobe("%m reset=%b flush=%b stall=%b op=%s q=%h", reset, flush, stall, op.name(), q);
    end
`else
`endif
endmodule

// File: tb/tb_flopr.sv
// tb_flopr: directed plus randomized checks of flopr against a behavioural model
module tb_flopr;
    logic        clk = 0;
    logic        reset, stall, flush;
    logic [31:0] d32, q32, m32;
    logic [7:0]  d8, q8, m8;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    flopr u32 (.clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d32), .q(q32));

    flopr #(.WIDTH(8), .RESET_VALUE(8'hA5), .FLUSH_VALUE(8'h3C)) u8 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d8), .q(q8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge: the model applies the priority rules, then both DUTs are checked.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (reset === 1'b1) begin
            m32 = 32'h0;
            m8  = 8'hA5;
        end else if (flush) begin
            m32 = 32'h0;
            m8  = 8'h3C;
        end else if (!stall) begin
            m32 = d32;
            m8  = d8;
        end
        #1;
        check({tag, "_q32"}, q32, m32);
        check({tag, "_q8"}, {24'h0, q8}, {24'h0, m8});
    endtask

    task automatic drive(input logic r, input logic f, input logic s, input logic [31:0] dv);
        reset = r;
        flush = f;
        stall = s;
        d32   = dv;
        d8    = dv[7:0];
    endtask

    initial begin
        drive(1, 0, 0, 32'h0);
        #2;
        cycle("reset_init");
        drive(0, 0, 0, 32'h12345678);
        cycle("load_12345678");
        drive(1, 1, 1, 32'h0);
        cycle("reset_over_all");
        drive(0, 0, 0, 32'hDEADBEEF);
        cycle("load_deadbeef");
        d32 = 32'h0;
        d8  = 8'h0;
        #3;
        check("between_edges_d", q32, 32'hDEADBEEF);
        drive(0, 0, 0, 32'hCAFEF00D);
        cycle("load_cafef00d");
        drive(0, 0, 1, 32'h11111111);
        for (int i = 0; i < 3; i++) begin
            cycle("stall_hold");
            check("stall_const", q32, 32'hCAFEF00D);
        end
        stall = 0;
        cycle("stall_release");
        check("release_val", q32, 32'h11111111);
        drive(0, 0, 0, 32'hAAAA5555);
        cycle("load_aaaa5555");
        drive(0, 1, 1, 32'hFFFFFFFF);
        cycle("flush_over_stall");
        check("flush_val8", {24'h0, q8}, 32'h3C);
        drive(0, 0, 0, 32'h000000FF);
        cycle("load_ff");
        check("load_val8", {24'h0, q8}, 32'hFF);
        reset = 1;
        #1;
        reset = 0;
        #1;
        check("sync_reset_pulse32", q32, 32'hFF);
        check("sync_reset_pulse8", {24'h0, q8}, 32'hFF);
        drive(0, 0, 1, 32'h5);
        cycle("stall_pre_reset");
        reset = 1;
        cycle("reset_mid_stall");
        drive(1, 1'bx, 1'bx, 32'h77);
        cycle("reset_x_ctrl");
        drive(0, 0, 0, 32'h9ABCDEF0);
        cycle("after_reset_load");
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(15) == 0, $urandom_range(5) == 0, $urandom_range(2) == 0, $urandom);
            cycle("random");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
